// File: rtl/taillight_seq.sv
// Tail-light controller: sequential turn sweep per side, steady brake light and
// a synchronised hazard flash for both sides. All outputs are registered and are
// derived from next-state values so lamps move on the same edge as the state.
module taillight_seq #(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             brake,
  input  logic             alarm,
  output logic [LAMPS-1:0] l_lamps,
  output logic [LAMPS-1:0] r_lamps,
  output logic             hazard_active
);

  localparam int IDX_W = $clog2(LAMPS + 1);
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [IDX_W-1:0] K_FIRST  = IDX_W'(1);
  localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(LAMPS);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    GAP
  } side_e;

  // Step index k is only meaningful in SWEEP; it is held at 0 elsewhere.
  typedef struct packed {
    side_e            st;
    logic [IDX_W-1:0] k;
  } side_t;

  localparam side_t SIDE_IDLE  = '{st: IDLE,  k: '0};
  localparam side_t SIDE_FIRST = '{st: SWEEP, k: K_FIRST};
  localparam side_t SIDE_GAP   = '{st: GAP,   k: '0};

  logic [DIV_W-1:0] div;
  side_t            l_side, r_side;
  side_t            l_nxt, r_nxt;
  logic             hz_phase, hz_nxt;
  logic             tick, hazard;

  assign tick   = (div == DIV_LAST);
  assign hazard = alarm | (left & right);

  // Advance one side's sequencer by one step when the prescaler ticks.
  function automatic side_t side_next(input side_t cur, input logic turn, input logic tk);
    side_t nxt;
    nxt = cur;
    if (tk) begin
      case (cur.st)
        IDLE:    nxt = turn ? SIDE_FIRST : SIDE_IDLE;
        SWEEP:   nxt = (cur.k == K_LAST) ? SIDE_GAP : '{st: SWEEP, k: cur.k + K_FIRST};
        GAP:     nxt = turn ? SIDE_FIRST : SIDE_IDLE;
        default: nxt = SIDE_IDLE;
      endcase
    end
    return nxt;
  endfunction

  // Lamp pattern for one side outside hazard mode; brake only shows on an idle side.
  function automatic logic [LAMPS-1:0] side_lamps(input side_t s, input logic brk);
    logic [LAMPS-1:0] m;
    m = '0;
    case (s.st)
      SWEEP: begin
        for (int i = 0; i < LAMPS; i++) m[i] = (i < int'(s.k));
      end
      GAP:     m = '0;
      default: m = {LAMPS{brk}};
    endcase
    return m;
  endfunction

  // Next-state computation: hazard aborts both sweeps and drives the shared flash phase.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    l_nxt  = SIDE_IDLE;
    r_nxt  = SIDE_IDLE;
    hz_nxt = 1'b0;
    if (hazard) begin
      hz_nxt = hz_phase ^ tick;
    end else begin
      l_nxt = side_next(l_side, left,  tick);
      r_nxt = side_next(r_side, right, tick);
    end
  end

  // State and registered outputs, with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      div           <= '0;
      l_side        <= SIDE_IDLE;
      r_side        <= SIDE_IDLE;
      hz_phase      <= 1'b0;
      l_lamps       <= '0;
      r_lamps       <= '0;
      hazard_active <= 1'b0;
    end else begin
      div           <= tick ? '0 : div + DIV_ONE;
      l_side        <= l_nxt;
      r_side        <= r_nxt;
      hz_phase      <= hz_nxt;
      l_lamps       <= hazard ? {LAMPS{hz_nxt}} : side_lamps(l_nxt, brake);
      r_lamps       <= hazard ? {LAMPS{hz_nxt}} : side_lamps(r_nxt, brake);
      hazard_active <= hazard;
    end
  end

endmodule

// File: tb/tb_taillight_seq.sv
// Bench for taillight_seq: two configurations (3 lamps / step every clock, and
// 4 lamps / step every 4 clocks) share one set of inputs. Stimulus pushes the
// model's expected outputs into a queue; a monitor pops and compares after each edge.
module tb_taillight_seq;

  logic clk = 1'b0;
  logic reset, left, right, brake, alarm;
  logic [2:0] l_a, r_a;
  logic [3:0] l_b, r_b;
  logic       h_a, h_b;

  always #5 clk = ~clk;

  taillight_seq #(.LAMPS(3), .TICK_DIV(1)) dut_a (
    .clk(clk), .reset(reset), .left(left), .right(right), .brake(brake), .alarm(alarm),
    .l_lamps(l_a), .r_lamps(r_a), .hazard_active(h_a)
  );

  taillight_seq #(.LAMPS(4), .TICK_DIV(4)) dut_b (
    .clk(clk), .reset(reset), .left(left), .right(right), .brake(brake), .alarm(alarm),
    .l_lamps(l_b), .r_lamps(r_b), .hazard_active(h_b)
  );

  typedef struct {
    string      name;
    logic [7:0] la, ra, lb, rb;
    logic       ha, hb;
    bit         lit_a;
    logic [7:0] lit_la, lit_ra;
    bit         lit_b;
    logic [7:0] lit_lb, lit_rb;
    logic       lit_hb;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model. A side's position in its repeating cycle: 0 = not signalling,
  // 1..L = that many lamps lit, L+1 = dark pause before the next sweep.
  int lamps_of[2] = '{3, 4};
  int div_of[2]   = '{1, 4};
  int pos_l[2], pos_r[2], phase[2], edges[2];

  function automatic int advance(input int pos, input int n, input logic turn);
    if (pos == 0 || pos == n + 1) return turn ? 1 : 0;
    return pos + 1;
  endfunction

  function automatic logic [7:0] pattern(input int pos, input int n, input logic brk);
    if (pos == 0) return brk ? 8'((1 << n) - 1) : 8'h00;
    if (pos == n + 1) return 8'h00;
    return 8'((1 << pos) - 1);
  endfunction

  task automatic model_edge(input int c, input logic rs, lf, rt, bk, al,
                            output logic [7:0] lo, ro, output logic ho);
    int  n;
    bit  hz, tk;
    n = lamps_of[c];
    if (!rs) begin
      pos_l[c] = 0; pos_r[c] = 0; phase[c] = 0; edges[c] = 0;
      lo = 0; ro = 0; ho = 0;
      return;
    end
    tk = ((edges[c] % div_of[c]) == div_of[c] - 1);
    edges[c]++;
    hz = al | (lf & rt);
    ho = hz;
    if (hz) begin
      pos_l[c] = 0; pos_r[c] = 0;
      if (tk) phase[c] = 1 - phase[c];
      lo = phase[c] ? 8'((1 << n) - 1) : 8'h00;
      ro = lo;
    end else begin
      phase[c] = 0;
      if (tk) begin
        pos_l[c] = advance(pos_l[c], n, lf);
        pos_r[c] = advance(pos_r[c], n, rt);
      end
      lo = pattern(pos_l[c], n, bk);
      ro = pattern(pos_r[c], n, bk);
    end
  endtask

  // Apply one cycle of inputs, record what both instances must show after the edge.
  task automatic step(input string name, input logic rs, lf, rt, bk, al,
                      input bit la_en = 0, input logic [7:0] lla = 0, input logic [7:0] lra = 0,
                      input bit lb_en = 0, input logic [7:0] llb = 0, input logic [7:0] lrb = 0,
                      input logic lhb = 0);
    exp_t e;
    reset = rs; left = lf; right = rt; brake = bk; alarm = al;
    e.name = name;
    model_edge(0, rs, lf, rt, bk, al, e.la, e.ra, e.ha);
    model_edge(1, rs, lf, rt, bk, al, e.lb, e.rb, e.hb);
    e.lit_a = la_en; e.lit_la = lla; e.lit_ra = lra;
    e.lit_b = lb_en; e.lit_lb = llb; e.lit_rb = lrb; e.lit_hb = lhb;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: after every rising edge compare whatever expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.name, " l_a"}, {5'b0, l_a}, e.la);
        check({e.name, " r_a"}, {5'b0, r_a}, e.ra);
        check({e.name, " h_a"}, {7'b0, h_a}, {7'b0, e.ha});
        check({e.name, " l_b"}, {4'b0, l_b}, e.lb);
        check({e.name, " r_b"}, {4'b0, r_b}, e.rb);
        check({e.name, " h_b"}, {7'b0, h_b}, {7'b0, e.hb});
        if (e.lit_a) begin
          check({e.name, " l_a literal"}, {5'b0, l_a}, e.lit_la);
          check({e.name, " r_a literal"}, {5'b0, r_a}, e.lit_ra);
        end
        if (e.lit_b) begin
          check({e.name, " l_b literal"}, {4'b0, l_b}, e.lit_lb);
          check({e.name, " r_b literal"}, {4'b0, r_b}, e.lit_rb);
          check({e.name, " h_b literal"}, {7'b0, h_b}, {7'b0, e.lit_hb});
        end
      end
    end
  end

  initial begin
    logic [7:0] t1[5];
    logic [7:0] t2[7];
    int         wait_cnt;
    logic       lf, rt, bk, al, rs;
    t1 = '{8'h1, 8'h3, 8'h7, 8'h0, 8'h1};
    t2 = '{8'h1, 8'h3, 8'h7, 8'h0, 8'h0, 8'h0, 8'h0};

    // Reset state
    step("reset", 0, 0, 0, 0, 0, 1, 8'h0, 8'h0, 1, 8'h0, 8'h0, 1'b0);

    // Held left turn: full sweep, gap, restart
    for (int i = 0; i < 5; i++) step("left_hold", 1, 1, 0, 0, 0, 1, t1[i], 8'h0);

    // One-cycle left pulse: sweep completes, then idle
    step("pulse_rst", 0, 0, 0, 0, 0);
    step("left_pulse", 1, 1, 0, 0, 0, 1, t2[0], 8'h0);
    for (int i = 1; i < 7; i++) step("left_pulse", 1, 0, 0, 0, 0, 1, t2[i], 8'h0);

    // Right sweeping with brake: brake lights idle left only
    step("brake_rst", 0, 0, 0, 0, 0);
    step("right_brake", 1, 0, 1, 0, 0, 1, 8'h0, 8'h1);
    step("right_brake", 1, 0, 1, 1, 0, 1, 8'h7, 8'h3);
    step("right_brake", 1, 0, 1, 1, 0, 1, 8'h7, 8'h7);
    step("right_brake", 1, 0, 1, 1, 0, 1, 8'h7, 8'h0);
    step("brake_off",   1, 0, 0, 0, 0, 1, 8'h0, 8'h0);

    // Alarm from reset release on the slow 4-lamp instance
    step("alarm_rst", 0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++)
      step("alarm_flash", 1, 0, 0, 0, 1, 0, 8'h0, 8'h0, 1,
           (i >= 3 && i <= 6) ? 8'hF : 8'h0, (i >= 3 && i <= 6) ? 8'hF : 8'h0, 1'b1);

    // Left sweep aborted by both-turn hazard, then stays idle
    step("abort_rst", 0, 0, 0, 0, 0);
    step("abort", 1, 1, 0, 0, 0, 1, 8'h1, 8'h0);
    step("abort", 1, 1, 0, 0, 0, 1, 8'h3, 8'h0);
    step("abort", 1, 1, 1, 0, 0, 1, 8'h7, 8'h7);
    step("abort", 1, 1, 1, 0, 0, 1, 8'h0, 8'h0);
    step("abort", 1, 1, 1, 0, 0, 1, 8'h7, 8'h7);
    for (int i = 0; i < 4; i++) step("abort_idle", 1, 0, 0, 0, 0, 1, 8'h0, 8'h0);

    // Reset mid-sweep with hazard active
    step("midrst_rst", 0, 0, 0, 0, 0);
    step("midrst", 1, 1, 0, 0, 0);
    step("midrst", 1, 1, 0, 0, 1);
    step("midrst", 1, 1, 0, 0, 1);
    step("midrst_reset", 0, 1, 0, 0, 1, 1, 8'h0, 8'h0, 1, 8'h0, 8'h0, 1'b0);
    for (int i = 0; i < 6; i++) step("midrst_quiet", 1, 0, 0, 0, 0, 1, 8'h0, 8'h0, 1, 8'h0, 8'h0, 1'b0);

    // Randomised input runs with occasional reset
    lf = 0; rt = 0; bk = 0; al = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        lf = 1'($urandom_range(0, 1));
        rt = 1'($urandom_range(0, 2) == 0);
        bk = 1'($urandom_range(0, 2) == 0);
        al = 1'($urandom_range(0, 9) == 0);
      end
      rs = 1'($urandom_range(0, 59) != 0);
      step("random", rs, lf, rt, bk, al);
    end

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      #2;
      wait_cnt++;
    end
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
